// File: rtl/sayeh_fetch_pkg.sv
// Shared definitions for the SAYEH instruction fetch path: FSM state
// encoding, the default short-instruction prefix and the zero-extend helper
// used when a packed 8-bit instruction is presented on the 16-bit bus.
package sayeh_fetch_pkg;

    localparam int WORD_W       = 16;
    localparam int SHORT_W      = 8;
    localparam int SHORT_ZEXT_W = WORD_W - SHORT_W;

    localparam logic [3:0] SHORT_PREFIX_DEF = 4'h0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        READ    = 2'd1,
        DELIVER = 2'd2
    } fetch_state_t;

    // Short instructions sit in the low byte of the presented word.
    function automatic logic [WORD_W-1:0] zext_short(input logic [SHORT_W-1:0] b);
        return {{SHORT_ZEXT_W{1'b0}}, b};
    endfunction

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Wait counter for an outstanding memory read. Held at zero while cleared,
// counts cycles in which the read is still waiting, and flags the cycle in
// which one more wait would reach TIMEOUT.
module fetch_timeout_ctr #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic inc,
    output logic hit
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt;

    // Count waiting cycles; clearing wins so every new read starts from zero.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign hit = (cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/instr_fetch_unit.sv
// SAYEH instruction fetch unit: reads the word at the current PC with a
// ready handshake and hands instructions to the controller one at a time.
// A word whose top nibble equals SHORT_PREFIX carries two 8-bit instructions;
// both are presented (high byte first) from a single read and PC increment.
// Optional read timeout with sticky fetch_err: define INSTR_FETCH_TIMEOUT_EN.
module instr_fetch_unit
    import sayeh_fetch_pkg::*;
#(
    parameter int         ADDR_W       = 16,
    parameter logic [3:0] SHORT_PREFIX = SHORT_PREFIX_DEF,
    parameter int         TIMEOUT      = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              fetch_req,
    input  logic              flush,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read,
    input  logic [WORD_W-1:0] mem_data,
    input  logic              mem_ready,
    output logic [WORD_W-1:0] instr,
    output logic              instr_valid,
    input  logic              instr_ack,
    output logic              is_short,
    output logic              pc_inc,
    output logic              fetch_err
);

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("instr_fetch_unit: TIMEOUT must be at least 1");
    end

    fetch_state_t state, state_n;

    // Low byte of a packed pair, kept until the high half is consumed.
    logic [SHORT_W-1:0] word_lo, word_lo_n;
    logic               pending_lo, pending_lo_n;
    // A flush arrived while a read was outstanding; drop its data on return.
    logic               drop_rd, drop_rd_n;

    logic [ADDR_W-1:0]  mem_addr_n;
    logic               mem_read_n;
    logic [WORD_W-1:0]  instr_n;
    logic               instr_valid_n;
    logic               is_short_n;
    logic               pc_inc_n;

`ifdef INSTR_FETCH_TIMEOUT_EN
    logic to_hit;
    logic err_set;

    fetch_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk   (clk),
        .rst   (rst),
        .clear (state != READ),
        .inc   ((state == READ) && !mem_ready),
        .hit   (to_hit)
    );

    // Sticky timeout flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_err <= 1'b0;
        end else if (err_set) begin
            fetch_err <= 1'b1;
        end
    end
`else
    assign fetch_err = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state and next-output decode; every register holds by default.
    always_comb begin
        state_n       = state;
        mem_addr_n    = mem_addr;
        mem_read_n    = mem_read;
        instr_n       = instr;
        instr_valid_n = instr_valid;
        is_short_n    = is_short;
        pc_inc_n      = 1'b0;
        word_lo_n     = word_lo;
        pending_lo_n  = pending_lo;
        drop_rd_n     = drop_rd;
`ifdef INSTR_FETCH_TIMEOUT_EN
        err_set       = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (fetch_req) begin
                    mem_addr_n = pc_in;
                    mem_read_n = 1'b1;
                    drop_rd_n  = 1'b0;
                    state_n    = READ;
                end
            end
            READ: begin
                if (mem_ready) begin
                    mem_read_n = 1'b0;
                    if (flush || drop_rd) begin
                        // Read completed after a jump: discard, no PC advance.
                        drop_rd_n     = 1'b0;
                        instr_valid_n = 1'b0;
                        state_n       = IDLE;
                    end else begin
                        pc_inc_n      = 1'b1;
                        instr_valid_n = 1'b1;
                        state_n       = DELIVER;
                        if (mem_data[15:12] == SHORT_PREFIX) begin
                            instr_n      = zext_short(mem_data[15:8]);
                            is_short_n   = 1'b1;
                            pending_lo_n = 1'b1;
                            word_lo_n    = mem_data[7:0];
                        end else begin
                            instr_n      = mem_data;
                            is_short_n   = 1'b0;
                            pending_lo_n = 1'b0;
                        end
                    end
`ifdef INSTR_FETCH_TIMEOUT_EN
                end else if (to_hit) begin
                    mem_read_n = 1'b0;
                    drop_rd_n  = 1'b0;
                    err_set    = 1'b1;
                    state_n    = IDLE;
`endif
                end else if (flush) begin
                    drop_rd_n = 1'b1;
                end
            end
            DELIVER: begin
                if (flush) begin
                    instr_valid_n = 1'b0;
                    pending_lo_n  = 1'b0;
                    state_n       = IDLE;
                end else if (instr_ack) begin
                    if (pending_lo) begin
                        // Second half of a packed pair: no memory access.
                        instr_n      = zext_short(word_lo);
                        is_short_n   = 1'b1;
                        pending_lo_n = 1'b0;
                    end else if (fetch_req) begin
                        mem_addr_n    = pc_in;
                        mem_read_n    = 1'b1;
                        instr_valid_n = 1'b0;
                        drop_rd_n     = 1'b0;
                        state_n       = READ;
                    end else begin
                        instr_valid_n = 1'b0;
                        state_n       = IDLE;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Output and datapath registers; reset clears everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_addr    <= '0;
            mem_read    <= 1'b0;
            instr       <= '0;
            instr_valid <= 1'b0;
            is_short    <= 1'b0;
            pc_inc      <= 1'b0;
            word_lo     <= '0;
            pending_lo  <= 1'b0;
            drop_rd     <= 1'b0;
        end else begin
            mem_addr    <= mem_addr_n;
            mem_read    <= mem_read_n;
            instr       <= instr_n;
            instr_valid <= instr_valid_n;
            is_short    <= is_short_n;
            pc_inc      <= pc_inc_n;
            word_lo     <= word_lo_n;
            pending_lo  <= pending_lo_n;
            drop_rd     <= drop_rd_n;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus a
// randomized run checked against an instruction-stream model.
module tb_instr_fetch_unit;

    localparam int         ADDR_W = 16;
    localparam int         TO_T   = 4;
    localparam logic [3:0] PFX    = 4'h0;

    logic              clk = 1'b0;
    logic              rst;
    logic [ADDR_W-1:0] pc_in;
    logic              fetch_req;
    logic              flush;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_read;
    logic [15:0]       mem_data;
    logic              mem_ready;
    logic [15:0]       instr;
    logic              instr_valid;
    logic              instr_ack;
    logic              is_short;
    logic              pc_inc;
    logic              fetch_err;

    int n_checks = 0;
    int n_fail   = 0;
    int pc_inc_total = 0;
    int rd_rise_total = 0;
    logic mr_prev = 1'b0;

    instr_fetch_unit #(
        .ADDR_W       (ADDR_W),
        .SHORT_PREFIX (PFX),
        .TIMEOUT      (TO_T)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pc_in       (pc_in),
        .fetch_req   (fetch_req),
        .flush       (flush),
        .mem_addr    (mem_addr),
        .mem_read    (mem_read),
        .mem_data    (mem_data),
        .mem_ready   (mem_ready),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ack   (instr_ack),
        .is_short    (is_short),
        .pc_inc      (pc_inc),
        .fetch_err   (fetch_err)
    );

    always #5 clk = ~clk;

    // Event counters sampled on the falling edge.
    always @(negedge clk) begin
        if (pc_inc === 1'b1) pc_inc_total++;
        if (mem_read === 1'b1 && mr_prev !== 1'b1) rd_rise_total++;
        mr_prev = mem_read;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_fetch(input logic [15:0] pc);
        pc_in     = pc;
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({mem_addr, mem_read, instr, instr_valid, is_short, pc_inc, fetch_err} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: addr=%h rd=%b instr=%h v=%b s=%b inc=%b err=%b, want all 0",
                     mem_addr, mem_read, instr, instr_valid, is_short, pc_inc, fetch_err);
        end
        rst = 1'b0;
        tick();
        n_checks++;
        if (mem_read !== 1'b0 || instr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: rd=%b v=%b want 0 0", mem_read, instr_valid);
        end
    endtask

    task automatic test_normal();
        do_fetch(16'h0010);
        n_checks++;
        if (mem_read !== 1'b1 || mem_addr !== 16'h0010) begin
            n_fail++;
            $display("FAIL normal_issue: rd=%b addr=%h want 1 0010", mem_read, mem_addr);
        end
        tick();
        n_checks++;
        if (mem_read !== 1'b1 || mem_addr !== 16'h0010 || instr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL normal_wait: rd=%b addr=%h v=%b want 1 0010 0", mem_read, mem_addr, instr_valid);
        end
        mem_ready = 1'b1;
        mem_data  = 16'h5A3C;
        tick();
        mem_ready = 1'b0;
        mem_data  = 16'hFFFF;
        n_checks++;
        if (instr_valid !== 1'b1 || instr !== 16'h5A3C || is_short !== 1'b0 || pc_inc !== 1'b1 || mem_read !== 1'b0) begin
            n_fail++;
            $display("FAIL normal_data: v=%b instr=%h s=%b inc=%b rd=%b want 1 5a3c 0 1 0",
                     instr_valid, instr, is_short, pc_inc, mem_read);
        end
        tick();
        n_checks++;
        if (pc_inc !== 1'b0 || instr_valid !== 1'b1 || instr !== 16'h5A3C) begin
            n_fail++;
            $display("FAIL normal_hold: inc=%b v=%b instr=%h want 0 1 5a3c", pc_inc, instr_valid, instr);
        end
        instr_ack = 1'b1;
        tick();
        instr_ack = 1'b0;
        n_checks++;
        if (instr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL normal_ack: v=%b want 0", instr_valid);
        end
    endtask

    task automatic test_packed();
        int p0 = pc_inc_total;
        int r0 = rd_rise_total;
        do_fetch(16'h0020);
        mem_ready = 1'b1;
        mem_data  = 16'h0B07;
        tick();
        mem_ready = 1'b0;
        n_checks++;
        if (instr_valid !== 1'b1 || instr !== 16'h000B || is_short !== 1'b1) begin
            n_fail++;
            $display("FAIL packed_hi: v=%b instr=%h s=%b want 1 000b 1", instr_valid, instr, is_short);
        end
        instr_ack = 1'b1;
        tick();
        n_checks++;
        if (instr_valid !== 1'b1 || instr !== 16'h0007 || is_short !== 1'b1 || pc_inc !== 1'b0 || mem_read !== 1'b0) begin
            n_fail++;
            $display("FAIL packed_lo: v=%b instr=%h s=%b inc=%b rd=%b want 1 0007 1 0 0",
                     instr_valid, instr, is_short, pc_inc, mem_read);
        end
        tick();
        instr_ack = 1'b0;
        n_checks++;
        if (instr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL packed_done: v=%b want 0", instr_valid);
        end
        tick();
        n_checks++;
        if (pc_inc_total - p0 != 1 || rd_rise_total - r0 != 1) begin
            n_fail++;
            $display("FAIL packed_counts: pc_inc=%0d reads=%0d want 1 1", pc_inc_total - p0, rd_rise_total - r0);
        end
    endtask

    task automatic test_back_to_back();
        do_fetch(16'h0010);
        mem_ready = 1'b1;
        mem_data  = 16'h1234;
        tick();
        mem_ready = 1'b0;
        pc_in     = 16'h0011;
        instr_ack = 1'b1;
        fetch_req = 1'b1;
        tick();
        instr_ack = 1'b0;
        fetch_req = 1'b0;
        n_checks++;
        if (mem_read !== 1'b1 || mem_addr !== 16'h0011 || instr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_issue: rd=%b addr=%h v=%b want 1 0011 0", mem_read, mem_addr, instr_valid);
        end
        mem_ready = 1'b1;
        mem_data  = 16'hABCD;
        tick();
        mem_ready = 1'b0;
        n_checks++;
        if (instr_valid !== 1'b1 || instr !== 16'hABCD || pc_inc !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_data: v=%b instr=%h inc=%b want 1 abcd 1", instr_valid, instr, pc_inc);
        end
        instr_ack = 1'b1;
        tick();
        instr_ack = 1'b0;
    endtask

    task automatic test_flush_read();
        int p0 = pc_inc_total;
        do_fetch(16'h0030);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_checks++;
        if (mem_read !== 1'b1 || mem_addr !== 16'h0030) begin
            n_fail++;
            $display("FAIL flush_rd_hold: rd=%b addr=%h want 1 0030", mem_read, mem_addr);
        end
        mem_ready = 1'b1;
        mem_data  = 16'h1111;
        tick();
        mem_ready = 1'b0;
        n_checks++;
        if (instr_valid !== 1'b0 || pc_inc !== 1'b0 || mem_read !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_rd_drop: v=%b inc=%b rd=%b want 0 0 0", instr_valid, pc_inc, mem_read);
        end
        tick();
        n_checks++;
        if (instr_valid !== 1'b0 || pc_inc_total != p0) begin
            n_fail++;
            $display("FAIL flush_rd_quiet: v=%b pc_inc=%0d want 0 0", instr_valid, pc_inc_total - p0);
        end
        // Unit must be idle: a fresh fetch behaves normally.
        do_fetch(16'h0031);
        mem_ready = 1'b1;
        mem_data  = 16'h2222;
        tick();
        mem_ready = 1'b0;
        n_checks++;
        if (instr_valid !== 1'b1 || instr !== 16'h2222) begin
            n_fail++;
            $display("FAIL flush_rd_after: v=%b instr=%h want 1 2222", instr_valid, instr);
        end
        instr_ack = 1'b1;
        tick();
        instr_ack = 1'b0;
    endtask

    task automatic test_flush_pair();
        do_fetch(16'h0040);
        mem_ready = 1'b1;
        mem_data  = 16'h0C05;
        tick();
        mem_ready = 1'b0;
        n_checks++;
        if (instr_valid !== 1'b1 || instr !== 16'h000C) begin
            n_fail++;
            $display("FAIL flush_pair_hi: v=%b instr=%h want 1 000c", instr_valid, instr);
        end
        flush     = 1'b1;
        instr_ack = 1'b1;
        tick();
        flush     = 1'b0;
        instr_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (instr_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL flush_pair_lo: cycle %0d v=%b instr=%h want v=0", i, instr_valid, instr);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_read();
        int p0;
        do_fetch(16'h0050);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        p0 = pc_inc_total;
        n_checks++;
        if ({mem_addr, mem_read, instr, instr_valid, is_short, pc_inc, fetch_err} !== '0) begin
            n_fail++;
            $display("FAIL rstmid_outputs: addr=%h rd=%b instr=%h v=%b s=%b inc=%b err=%b want all 0",
                     mem_addr, mem_read, instr, instr_valid, is_short, pc_inc, fetch_err);
        end
        mem_ready = 1'b1;
        mem_data  = 16'h0B07;
        tick();
        mem_ready = 1'b0;
        tick();
        n_checks++;
        if (instr_valid !== 1'b0 || mem_read !== 1'b0 || pc_inc_total != p0) begin
            n_fail++;
            $display("FAIL rstmid_stale: v=%b rd=%b pc_inc=%0d want 0 0 0", instr_valid, mem_read, pc_inc_total - p0);
        end
    endtask

    task automatic test_timeout();
`ifdef INSTR_FETCH_TIMEOUT_EN
        do_fetch(16'h0060);
        for (int i = 0; i < TO_T - 1; i++) begin
            n_checks++;
            if (mem_read !== 1'b1 || fetch_err !== 1'b0) begin
                n_fail++;
                $display("FAIL timeout_wait: cycle %0d rd=%b err=%b want 1 0", i, mem_read, fetch_err);
            end
            tick();
        end
        n_checks++;
        if (mem_read !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_last: rd=%b want 1", mem_read);
        end
        tick();
        n_checks++;
        if (mem_read !== 1'b0 || fetch_err !== 1'b1 || pc_inc !== 1'b0 || instr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_fire: rd=%b err=%b inc=%b v=%b want 0 1 0 0", mem_read, fetch_err, pc_inc, instr_valid);
        end
        tick();
        do_fetch(16'h0061);
        mem_ready = 1'b1;
        mem_data  = 16'h3333;
        tick();
        mem_ready = 1'b0;
        n_checks++;
        if (instr_valid !== 1'b1 || instr !== 16'h3333 || fetch_err !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_sticky: v=%b instr=%h err=%b want 1 3333 1", instr_valid, instr, fetch_err);
        end
        instr_ack = 1'b1;
        tick();
        instr_ack = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if (fetch_err !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_clear: err=%b want 0", fetch_err);
        end
`else
        do_fetch(16'h0060);
        for (int i = 0; i < 20; i++) tick();
        n_checks++;
        if (mem_read !== 1'b1 || fetch_err !== 1'b0 || mem_addr !== 16'h0060) begin
            n_fail++;
            $display("FAIL no_timeout: rd=%b err=%b addr=%h want 1 0 0060", mem_read, fetch_err, mem_addr);
        end
        mem_ready = 1'b1;
        mem_data  = 16'h3333;
        tick();
        mem_ready = 1'b0;
        n_checks++;
        if (instr_valid !== 1'b1 || instr !== 16'h3333) begin
            n_fail++;
            $display("FAIL no_timeout_data: v=%b instr=%h want 1 3333", instr_valid, instr);
        end
        instr_ack = 1'b1;
        tick();
        instr_ack = 1'b0;
`endif
    endtask

    // Random words and handshake timing against an instruction-stream model:
    // each word yields one full instruction, or two zero-extended bytes when
    // its top nibble is the short prefix; each word costs one read and one
    // PC increment.
    task automatic test_random();
        logic [15:0] exp_i[$];
        logic        exp_s[$];
        logic [15:0] pc, w, e;
        logic        s;
        int p0 = pc_inc_total;
        int r0 = rd_rise_total;
        int ntx = 40;
        for (int t = 0; t < ntx; t++) begin
            pc = 16'($urandom);
            w  = 16'($urandom);
            if ($urandom_range(0, 2) == 0) w[15:12] = PFX;
            mem_ready = 1'b1;
            mem_data  = 16'($urandom);
            tick();
            mem_ready = 1'b0;
            n_checks++;
            if (instr_valid !== 1'b0 || mem_read !== 1'b0) begin
                n_fail++;
                $display("FAIL rand_idle_ready: tx %0d v=%b rd=%b want 0 0", t, instr_valid, mem_read);
            end
            do_fetch(pc);
            for (int k = $urandom_range(0, 3); k > 0; k--) begin
                n_checks++;
                if (mem_read !== 1'b1 || mem_addr !== pc || instr_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rand_read: tx %0d rd=%b addr=%h v=%b want 1 %h 0", t, mem_read, mem_addr, instr_valid, pc);
                end
                tick();
            end
            n_checks++;
            if (mem_read !== 1'b1 || mem_addr !== pc) begin
                n_fail++;
                $display("FAIL rand_addr: tx %0d rd=%b addr=%h want 1 %h", t, mem_read, mem_addr, pc);
            end
            mem_ready = 1'b1;
            mem_data  = w;
            tick();
            mem_ready = 1'b0;
            mem_data  = 16'($urandom);
            if (w[15:12] == PFX) begin
                exp_i.push_back({8'h00, w[15:8]}); exp_s.push_back(1'b1);
                exp_i.push_back({8'h00, w[7:0]});  exp_s.push_back(1'b1);
            end else begin
                exp_i.push_back(w); exp_s.push_back(1'b0);
            end
            while (exp_i.size() > 0) begin
                e = exp_i.pop_front();
                s = exp_s.pop_front();
                for (int k = $urandom_range(0, 2); k >= 0; k--) begin
                    n_checks++;
                    if (instr_valid !== 1'b1 || instr !== e || is_short !== s) begin
                        n_fail++;
                        $display("FAIL rand_instr: tx %0d v=%b instr=%h s=%b want 1 %h %b", t, instr_valid, instr, is_short, e, s);
                    end
                    if (k > 0) tick();
                end
                instr_ack = 1'b1;
                tick();
                instr_ack = 1'b0;
            end
            n_checks++;
            if (instr_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL rand_end: tx %0d v=%b want 0", t, instr_valid);
            end
        end
        tick();
        n_checks++;
        if (pc_inc_total - p0 != ntx || rd_rise_total - r0 != ntx) begin
            n_fail++;
            $display("FAIL rand_counts: pc_inc=%0d reads=%0d want %0d %0d", pc_inc_total - p0, rd_rise_total - r0, ntx, ntx);
        end
    endtask

    initial begin
        rst       = 1'b1;
        pc_in     = '0;
        fetch_req = 1'b0;
        flush     = 1'b0;
        mem_data  = '0;
        mem_ready = 1'b0;
        instr_ack = 1'b0;
        test_reset();
        test_normal();
        test_packed();
        test_back_to_back();
        test_flush_read();
        test_flush_pair();
        test_reset_mid_read();
        test_timeout();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Reader side of the program-counter/memory path in the SAYEH CPU.
- Takes the current PC value and issues a memory read with a ready handshake.
- Latches the 16-bit word and presents instructions to the controller one at a time.
- A word holding two packed 8-bit short instructions is delivered as two instructions, with only one memory access and one PC increment.

Parameters:
- ADDR_W, 16, width of pc_in and mem_addr.
- SHORT_PREFIX, 4'h0, value of word[15:12] that marks a packed pair of short instructions.
- TIMEOUT, 15, cycles allowed for mem_ready (used only with the optional feature; must be at least 1).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- pc_in  in  ADDR_W  current PC value.
- fetch_req  in  1  controller requests the next instruction.
- flush  in  1  jump taken; discard any held or pending instruction.
- mem_addr  out  ADDR_W  read address.
- mem_read  out  1  read strobe, held until mem_ready.
- mem_data  in  16  memory read data.
- mem_ready  in  1  mem_data valid this cycle.
- instr  out  16  instruction presented; short instructions are zero-extended into [7:0].
- instr_valid  out  1  instr is valid.
- instr_ack  in  1  controller consumed instr.
- is_short  out  1  instr is a short (8-bit) instruction.
- pc_inc  out  1  one-cycle pulse telling the PC to advance.
- fetch_err  out  1  sticky timeout flag (optional feature only).

Behaviour:
- Reset values, applied synchronously: all outputs 0; FSM in IDLE; internal word register 0; pending-low flag 0.
- FSM states: IDLE, READ, DELIVER.
- IDLE:
  - fetch_req=1 → mem_addr<=pc_in, mem_read<=1, go to READ.
  - mem_ready in IDLE is ignored.
- READ:
  - mem_read stays high and mem_addr stays stable until mem_ready=1.
  - On mem_ready: capture mem_data; mem_read<=0; pc_inc<=1 for exactly one cycle; instr_valid<=1; go to DELIVER.
  - If mem_data[15:12]==SHORT_PREFIX: instr<={8'h00,mem_data[15:8]}, is_short<=1, pending_lo<=1.
  - Otherwise: instr<=mem_data, is_short<=0.
- Latency: request to instr_valid is 1 cycle plus the memory wait; a zero-wait memory gives instr_valid 2 cycles after fetch_req.
- DELIVER: instr_valid and instr are held until instr_ack.
  - On instr_ack with pending_lo=1: next cycle instr<={8'h00,word[7:0]}, is_short=1, pending_lo<=0, instr_valid stays 1. No memory access and no pc_inc.
  - On instr_ack with pending_lo=0 and fetch_req=1 in the same cycle: go directly to READ with mem_addr<=pc_in and instr_valid<=0 (back-to-back fetch, no IDLE cycle).
  - On instr_ack with pending_lo=0 and fetch_req=0: instr_valid<=0, go to IDLE.
- flush:
  - In DELIVER: instr_valid<=0, pending_lo<=0, go to IDLE.
  - In READ: the outstanding read is allowed to complete, then the data is dropped. Go to IDLE on mem_ready and suppress pc_inc.
  - flush has priority over instr_ack.
- Reset mid-READ: mem_read drops at the same edge; a stale mem_ready afterwards is ignored.
- PC address wrap 16'hFFFF→16'h0000 is the PC's concern; the fetch unit passes addresses through unmodified.
- pc_inc is never asserted for the low half of a packed pair.

Optional Feature:
- Macro: INSTR_FETCH_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entry to READ and increments each READ cycle without mem_ready.
  - When it reaches TIMEOUT: set fetch_err (sticky until rst), drop mem_read, go to IDLE, no pc_inc.
- Undefined:
  - READ waits indefinitely; fetch_err is tied to 0 and no counter logic is present.

Decomposition:
- Shared package sayeh_fetch_pkg:
  - state encoding constants (IDLE=2'd0, READ=2'd1, DELIVER=2'd2);
  - SHORT_PREFIX default;
  - short-instruction zero-extend width constant.
- One sub-module, fetch_timeout_ctr: the TIMEOUT counter. It is instantiated only under INSTR_FETCH_TIMEOUT_EN.

Test Plan:
- Normal fetch:
  - Stimulus: pc_in=16'h0010, fetch_req pulse, mem_ready 2 cycles after mem_read, mem_data=16'h5A3C.
  - Response: mem_addr=16'h0010; instr=16'h5A3C; is_short=0; pc_inc high exactly one cycle.
- Packed pair:
  - Stimulus: mem_data=16'h0B07, ack each instruction.
  - Response: instr=16'h000B then 16'h0007, both with is_short=1; one mem_read; one pc_inc.
- Back-to-back fetch:
  - Stimulus: instr_ack and fetch_req asserted together, pc_in=16'h0011.
  - Response: mem_read re-asserted next cycle with mem_addr=16'h0011; no IDLE cycle.
- Flush:
  - Stimulus: flush during READ, mem_ready one cycle later.
  - Response: instr_valid stays 0, pc_inc stays 0, FSM in IDLE.
  - Stimulus: flush while the high half of a pair is held.
  - Response: the low half is never presented.
- Reset mid-READ:
  - Stimulus: rst while mem_read=1, then mem_ready pulse.
  - Response: all outputs 0; the mem_ready is ignored.
- Timeout (INSTR_FETCH_TIMEOUT_EN, TIMEOUT=4):
  - Stimulus: mem_ready never asserted.
  - Response: mem_read drops after 4 cycles; fetch_err=1 and stays set until rst.
